// File: rtl/prod_accum.sv
// Product accumulator: sums N_TERMS unsigned 8-bit products per group and
// presents the group total with a valid/ready handshake and a sticky carry flag.
module prod_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  logic [ACC_W:0]   add;

  // One extra bit on the adder captures the carry out of the accumulator width.
  assign add = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (in_valid) begin
          acc   <= add[ACC_W-1:0];
          ovf_r <= ovf_r | add[ACC_W];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: if (out_ready) begin
          acc   <= '0;
          ovf_r <= 1'b0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Handshake flags depend on state alone, so no input-to-output paths exist.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign sum       = acc;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default instance plus a narrow ACC_W=9 copy
// sharing the same stimulus to exercise the overflow flag.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [7:0]  prod;
  logic        in_ready, out_valid, ovf;
  logic [11:0] sum;
  logic        in_ready9, out_valid9, ovf9;
  logic [8:0]  sum9;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  prod_accum dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  prod_accum #(.N_TERMS(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready9),
    .prod(prod), .out_valid(out_valid9), .out_ready(out_ready), .sum(sum9), .ovf(ovf9)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer four products back to back, then leave out_ready at rdy.
  task automatic group(input int a, input int b, input int c, input int d, input bit rdy);
    int p[4];
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      prod     = 8'(p[i]);
      chk("in_ready_accum", in_ready, 1);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = rdy;
  endtask

  task automatic expect_result(input string tag, input int s, input bit o);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_ovf"}, ovf, o);
    chk({tag, "_in_ready_hold"}, in_ready, 0);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    cycle();
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; prod = '0;
    cycle();
    cycle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Basic group, consumer ready: exactly one valid cycle
    group(6, 50, 225, 63, 1'b1);
    expect_result("basic", 344, 1'b0);
    accept("basic");

    // Backpressure: hold 5 cycles while a fifth product is offered
    group(6, 50, 225, 63, 1'b0);
    in_valid = 1'b1;
    prod     = 8'd99;
    for (int i = 0; i < 5; i++) begin
      expect_result("stall", 344, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    expect_result("stall_end", 344, 1'b0);
    accept("stall");
    group(1, 2, 3, 4, 1'b1);
    expect_result("after_stall", 10, 1'b0);
    accept("after_stall");

    // Idle gaps between products
    in_valid = 1'b1; prod = 8'd6; cycle();
    in_valid = 1'b0; prod = 8'd77;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("gap_no_valid", out_valid, 0);
    end
    in_valid = 1'b1; prod = 8'd50; cycle();
    in_valid = 1'b0; cycle();
    in_valid = 1'b1; prod = 8'd225; cycle();
    prod = 8'd63; cycle();
    in_valid = 1'b0;
    expect_result("gaps", 344, 1'b0);
    accept("gaps");

    // clear mid-group discards the partial sum and the product offered with it
    in_valid = 1'b1; prod = 8'd6; cycle();
    prod = 8'd50; cycle();
    clear = 1'b1; prod = 8'd7; cycle();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_sum", sum, 0);
    group(225, 225, 225, 225, 1'b1);
    expect_result("clear", 900, 1'b0);
    chk("w9_sum", sum9, 388);
    chk("w9_ovf", ovf9, 1);
    chk("w9_valid", out_valid9, 1);
    accept("clear");
    group(1, 1, 1, 1, 1'b1);
    chk("w9_next_sum", sum9, 4);
    chk("w9_next_ovf", ovf9, 0);
    expect_result("ones", 4, 1'b0);
    accept("ones");

    // clear while holding with out_ready=1 drops the result
    group(6, 50, 225, 63, 1'b0);
    expect_result("hold_clear_pre", 344, 1'b0);
    clear = 1'b1; out_ready = 1'b1; cycle();
    clear = 1'b0; out_ready = 1'b0;
    chk("hold_clear_valid", out_valid, 0);
    chk("hold_clear_sum", sum, 0);
    chk("hold_clear_in_ready", in_ready, 1);

    // rst with a product offered mid-group
    in_valid = 1'b1; prod = 8'd6; cycle();
    prod = 8'd50; cycle();
    rst = 1'b1; prod = 8'd200; cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_ovf", ovf, 0);
    group(6, 50, 225, 63, 1'b1);
    expect_result("after_rst", 344, 1'b0);
    accept("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
